// File: rtl/popcnt_accumulator.sv
// popcnt_accumulator: reduces each 14-bit product vector to a popcount and
// accumulates popcounts per packet (terminated by in_last), emitting one
// saturating sum/beat-count result per packet on a valid/ready output.
// Pipeline: S1 holds the registered popcount, S2 is the accumulator/output FSM.

// adder_14to4: 14-input ones counter, result on {O3,O2,O1,O0}.
module adder_14to4 (
  input  logic [13:0] a,
  output logic        O3,
  output logic        O2,
  output logic        O1,
  output logic        O0
);

  logic [3:0] sum;

  // Count the set bits of the product vector.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      sum = sum + {3'b000, a[i]};
    end
  end

  assign {O3, O2, O1, O0} = sum;

endmodule

module popcnt_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_bits,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic             s1_valid;
  logic             s1_last;
  logic [3:0]       s1_pc;
  logic [3:0]       pc;
  logic             xfer;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_nxt;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_ovf;
  logic             ovf;

  adder_14to4 u_pc (
    .a  (in_bits),
    .O3 (pc[3]),
    .O2 (pc[2]),
    .O1 (pc[1]),
    .O0 (pc[0])
  );

  // S1 can take a beat whenever it is empty or the FSM drains it this cycle.
  assign in_ready = !s1_valid || (state == ACCUM);
  assign xfer     = in_valid && in_ready;

  // Saturating add of the staged popcount and saturating beat increment.
  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(s1_pc);
    sum_ovf = sum_ext[ACC_W];
    sum_nxt = sum_ovf ? '1 : sum_ext[ACC_W-1:0];
    cnt_ovf = &cnt;
    cnt_nxt = cnt_ovf ? cnt : cnt + CNT_W'(1);
    ovf     = sum_ovf || cnt_ovf;
  end

  // S1: capture popcount on transfer, empty once consumed, freeze during HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_pc    <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_pc    <= pc;
    end else if (state == ACCUM) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: accumulate within a packet, publish and hold the result at packet end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (s1_valid) begin
            if (!s1_last) begin
              acc <= sum_nxt;
              cnt <= cnt_nxt;
              sat <= sat || ovf;
            end else begin
              out_sum   <= sum_nxt;
              out_count <= cnt_nxt;
              out_sat   <= sat || ovf;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              sat       <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_accumulator.sv
// Bench for popcnt_accumulator: two instances (16/8 and 5/2 widths) share one
// stimulus stream; a packet-level reference model checks every result.
module tb_popcnt_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [13:0] in_bits;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_sum_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [4:0]  out_sum_b;
  logic [1:0]  out_count_b;

  popcnt_accumulator #(.ACC_W(16), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_bits(in_bits), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_sat(out_sat_a)
  );

  popcnt_accumulator #(.ACC_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bits(in_bits), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: packet totals, clamped on compare -------
  typedef struct {
    int unsigned sum;
    int unsigned cnt;
  } pkt_t;

  pkt_t        q0[$];
  pkt_t        q1[$];
  int unsigned part_sum[2];
  int unsigned part_cnt[2];
  logic [1:0]  m_ov, m_ir;
  int unsigned m_sum[2], m_cnt[2], m_sat[2];
  pkt_t        m_f;
  bit          m_have;
  int unsigned m_ms, m_mc, m_es, m_ec, m_ex;

  always @(negedge clk) begin
    m_ov = {out_valid_b, out_valid_a};
    m_ir = {in_ready_b, in_ready_a};
    m_sum[0] = 32'(out_sum_a);   m_sum[1] = 32'(out_sum_b);
    m_cnt[0] = 32'(out_count_a); m_cnt[1] = 32'(out_count_b);
    m_sat[0] = 32'(out_sat_a);   m_sat[1] = 32'(out_sat_b);
    if (reset) begin
      q0.delete();
      q1.delete();
      part_sum = '{0, 0};
      part_cnt = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_ms = (d == 0) ? 32'd65535 : 32'd31;
        m_mc = (d == 0) ? 32'd255 : 32'd3;
        if (d == 0) begin
          m_have = (q0.size() != 0);
          if (m_have) m_f = q0[0];
        end else begin
          m_have = (q1.size() != 0);
          if (m_have) m_f = q1[0];
        end
        if (m_ov[d]) begin
          chk($sformatf("valid_has_result_%0d", d), 32'(m_have), 1);
          if (m_have) begin
            m_es = (m_f.sum > m_ms) ? m_ms : m_f.sum;
            m_ec = (m_f.cnt > m_mc) ? m_mc : m_f.cnt;
            m_ex = (m_f.sum > m_ms || m_f.cnt > m_mc) ? 1 : 0;
            chk($sformatf("model_sum_%0d", d), m_sum[d], m_es);
            chk($sformatf("model_count_%0d", d), m_cnt[d], m_ec);
            chk($sformatf("model_sat_%0d", d), m_sat[d], m_ex);
            if (out_ready) begin
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
        if (in_valid && m_ir[d]) begin
          part_sum[d] += 32'($countones(in_bits));
          part_cnt[d] += 1;
          if (in_last) begin
            m_f.sum = part_sum[d];
            m_f.cnt = part_cnt[d];
            if (d == 0) q0.push_back(m_f);
            else        q1.push_back(m_f);
            part_sum[d] = 0;
            part_cnt[d] = 0;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted; returns at posedge+1 with in_valid low.
  task automatic drive_beat(input logic [13:0] bits, input logic last, output int unsigned acc_cyc);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    in_last  = last;
    acc_cyc  = 0;
    while (1'b1) begin
      @(negedge clk);
      if (in_ready_a) begin
        acc_cyc = cyc;
        break;
      end
      n++;
      if (n >= 200) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    @(negedge clk);
    while (!out_valid_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 32'(out_valid_a), 1);
  endtask

  task automatic check_result(input string tag,
                              input int unsigned sa, input int unsigned ca, input int unsigned xa,
                              input int unsigned sb, input int unsigned cb, input int unsigned xb);
    chk({tag, "_sum_a"},   32'(out_sum_a),   sa);
    chk({tag, "_count_a"}, 32'(out_count_a), ca);
    chk({tag, "_sat_a"},   32'(out_sat_a),   xa);
    chk({tag, "_sum_b"},   32'(out_sum_b),   sb);
    chk({tag, "_count_b"}, 32'(out_count_b), cb);
    chk({tag, "_sat_b"},   32'(out_sat_b),   xb);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [13:0] bits;
    logic        last;
    int unsigned sa, ca, xa, sb, cb, xb;
  } vec_t;

  vec_t        tbl[12];
  int unsigned ac;
  int unsigned acc_cyc5[20];
  bit          rnd_done = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // 3-beat packet; 3x full vector; single 7-bit vector; 4 single-bit beats; 1 full beat
    tbl[0]  = '{14'h3FFF, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{14'h0000, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{14'h0001, 1'b1, 15, 3, 0, 15, 3, 0};
    tbl[3]  = '{14'h3FFF, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{14'h3FFF, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{14'h3FFF, 1'b1, 42, 3, 0, 31, 3, 1};
    tbl[6]  = '{14'h007F, 1'b1, 7, 1, 0, 7, 1, 0};
    tbl[7]  = '{14'h0001, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{14'h0001, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{14'h0001, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{14'h0001, 1'b1, 4, 4, 0, 4, 3, 1};
    tbl[11] = '{14'h3FFF, 1'b1, 14, 1, 0, 14, 1, 0};

    // Reset held 2 clk with a beat offered: the beat must be discarded.
    reset = 1'b1; in_valid = 1'b1; in_bits = 14'h3FFF; in_last = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("rst_out_valid_a", 32'(out_valid_a), 0);
    chk("rst_out_valid_b", 32'(out_valid_b), 0);
    chk("rst_in_ready_a", 32'(in_ready_a), 1);
    chk("rst_in_ready_b", 32'(in_ready_b), 1);
    check_result("rst", 0, 0, 0, 0, 0, 0);
    sync();

    // Table packets with exact latency and one-cycle output pulse.
    for (int i = 0; i < 12; i++) begin
      drive_beat(tbl[i].bits, tbl[i].last, ac);
      if (tbl[i].last) begin
        @(negedge clk);
        chk($sformatf("lat_early_%0d", i), 32'(out_valid_a), 0);
        @(negedge clk);
        chk($sformatf("lat_rise_a_%0d", i), 32'(out_valid_a), 1);
        chk($sformatf("lat_rise_b_%0d", i), 32'(out_valid_b), 1);
        check_result($sformatf("tbl%0d", i), tbl[i].sa, tbl[i].ca, tbl[i].xa,
                     tbl[i].sb, tbl[i].cb, tbl[i].xb);
        @(negedge clk);
        chk($sformatf("pulse_1clk_%0d", i), 32'(out_valid_a), 0);
        sync();
      end
    end

    // Backpressure: result held 5 clk while the next packet streams in.
    out_ready = 1'b0;
    drive_beat(14'h0003, 1'b0, ac);
    drive_beat(14'h0005, 1'b1, ac);
    fork
      begin
        drive_beat(14'h00FF, 1'b0, ac);
        drive_beat(14'h0F0F, 1'b0, ac);
        drive_beat(14'h3000, 1'b1, ac);
      end
      begin
        wait_valid();
        repeat (5) @(negedge clk);
        chk("bp_in_ready_a", 32'(in_ready_a), 0);
        chk("bp_in_ready_b", 32'(in_ready_b), 0);
        chk("bp_held_valid", 32'(out_valid_a), 1);
        check_result("bp_held", 4, 2, 0, 4, 2, 0);
        sync();
        out_ready = 1'b1;
      end
    join
    wait_valid();
    check_result("bp_next", 18, 3, 0, 18, 3, 0);
    sync();

    // Back-to-back 1-beat packets: steady state one beat per 2 clk.
    for (int i = 0; i < 20; i++) begin
      drive_beat(14'($urandom), 1'b1, acc_cyc5[i]);
    end
    chk("b2b_rate_cycles", acc_cyc5[19] - acc_cyc5[3], 32);
    repeat (4) sync();

    // Count saturation on the wide instance: 300-beat packet of full vectors.
    for (int i = 0; i < 300; i++) begin
      drive_beat(14'h3FFF, (i == 299), ac);
    end
    wait_valid();
    check_result("long", 4200, 255, 1, 31, 3, 1);
    sync();

    // Reset after 2 of 4 beats, then a fresh 2-beat packet.
    drive_beat(14'h3FFF, 1'b0, ac);
    drive_beat(14'h3FFF, 1'b0, ac);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid_a), 0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 1);
    sync();
    drive_beat(14'h0003, 1'b0, ac);
    drive_beat(14'h0003, 1'b1, ac);
    wait_valid();
    check_result("mid_rst", 4, 2, 0, 4, 2, 0);
    sync();

    // Random packets, gaps and output backpressure against the model.
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int unsigned len;
          len = $urandom_range(1, 6);
          for (int b = 0; b < int'(len); b++) begin
            repeat ($urandom_range(0, 2)) sync();
            drive_beat(14'($urandom), (b == int'(len) - 1), ac);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          sync();
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) sync();
    chk("drain_pending_a", q0.size(), 0);
    chk("drain_pending_b", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
